// File: rtl/dvc_buffer_ctrl.sv
// Dynamic VC buffer controller: several VCs share one flit bank through
// per-VC linked lists, with unallocated slots tracked in a free-slot FIFO.
module dvc_buffer_ctrl #(
    parameter  int max_vc_number     = 10,
    parameter  int memory_bank_depth = 32,
    localparam int ptr_w = $clog2(memory_bank_depth),
    localparam int cnt_w = $clog2(memory_bank_depth + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_valid,
    input  logic [max_vc_number-1:0] push_vc,
    input  logic                     pop_valid,
    input  logic [max_vc_number-1:0] pop_vc,
    output logic                     push_ready,
    output logic                     write_valid,
    output logic [ptr_w-1:0]         write_addr,
    output logic                     read_valid,
    output logic [ptr_w-1:0]         read_addr,
    output logic [max_vc_number-1:0] vc_empty,
    output logic [cnt_w-1:0]         free_count,
    output logic                     error
);

    localparam int idx_w = (max_vc_number > 1) ? $clog2(max_vc_number) : 1;
    localparam logic [ptr_w-1:0] ptr_one = 1;
    localparam logic [cnt_w-1:0] cnt_one = 1;
    localparam logic [cnt_w-1:0] cnt_full = memory_bank_depth;

    logic [ptr_w-1:0] free_mem [memory_bank_depth];
    logic [ptr_w-1:0] free_rd;
    logic [ptr_w-1:0] free_wr;
    logic [cnt_w-1:0] free_cnt;

    logic [ptr_w-1:0] head     [max_vc_number];
    logic [ptr_w-1:0] tail     [max_vc_number];
    logic [cnt_w-1:0] vc_count [max_vc_number];
    logic [ptr_w-1:0] next_ptr [memory_bank_depth];

    logic [idx_w-1:0] push_idx;
    logic [idx_w-1:0] pop_idx;
    logic             push_onehot;
    logic             pop_onehot;
    logic             pop_tgt_empty;
    logic             push_ok;
    logic             pop_ok;
    logic             same_vc;
    logic             same_single;
    logic             err_d;
    logic             err_q;

    always_comb begin
        push_idx = '0;
        pop_idx  = '0;
        for (int i = 0; i < max_vc_number; i++) begin
            if (push_vc[i]) push_idx = idx_w'(i);
            if (pop_vc[i])  pop_idx  = idx_w'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < max_vc_number; i++) begin
            vc_empty[i] = (vc_count[i] == '0);
        end
    end

    assign push_onehot   = $onehot(push_vc);
    assign pop_onehot    = $onehot(pop_vc);
    assign pop_tgt_empty = vc_empty[pop_idx];

    assign push_ready = (free_cnt != '0);
    assign free_count = free_cnt;

    // Requests seen while reset is high never commit.
    assign push_ok = ~reset & push_valid & push_ready & push_onehot;
    assign pop_ok  = ~reset & pop_valid & pop_onehot & ~pop_tgt_empty;

    assign same_vc     = push_ok & pop_ok & (push_idx == pop_idx);
    assign same_single = same_vc & (vc_count[pop_idx] == cnt_one);

    assign write_valid = push_ok;
    assign write_addr  = free_mem[free_rd];
    assign read_valid  = pop_ok;
    assign read_addr   = head[pop_idx];

    assign err_d = ~reset &
                   ((push_valid & (~push_onehot | ~push_ready)) |
                    (pop_valid  & (~pop_onehot  | pop_tgt_empty)));

    assign error = err_q;

    // Free-slot FIFO; it starts full, so rd == wr at reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < memory_bank_depth; i++) begin
                free_mem[i] <= ptr_w'(i);
            end
            free_rd  <= '0;
            free_wr  <= '0;
            free_cnt <= cnt_full;
        end else begin
            if (push_ok) begin
                free_rd <= free_rd + ptr_one;
            end
            if (pop_ok) begin
                free_mem[free_wr] <= read_addr;
                free_wr           <= free_wr + ptr_one;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   free_cnt <= free_cnt - cnt_one;
                2'b01:   free_cnt <= free_cnt + cnt_one;
                default: free_cnt <= free_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < max_vc_number; i++) begin
                head[i]     <= '0;
                tail[i]     <= '0;
                vc_count[i] <= '0;
            end
            for (int i = 0; i < memory_bank_depth; i++) begin
                next_ptr[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                tail[push_idx] <= write_addr;
                if (vc_empty[push_idx]) begin
                    head[push_idx] <= write_addr;
                end else begin
                    next_ptr[tail[push_idx]] <= write_addr;
                end
            end
            // Popping the only flit while pushing the same VC: new flit becomes head.
            if (pop_ok) begin
                if (same_single) begin
                    head[pop_idx] <= write_addr;
                end else begin
                    head[pop_idx] <= next_ptr[head[pop_idx]];
                end
            end
            if (push_ok && !same_vc) begin
                vc_count[push_idx] <= vc_count[push_idx] + cnt_one;
            end
            if (pop_ok && !same_vc) begin
                vc_count[pop_idx] <= vc_count[pop_idx] - cnt_one;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_dvc_buffer_ctrl.sv
// Bench for dvc_buffer_ctrl: reference model of free FIFO and per-VC lists,
// scoreboard of expected bank addresses, plus directed corner sequences.
module tb_dvc_buffer_ctrl;

    localparam int NVC   = 10;
    localparam int DEPTH = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           push_valid;
    logic [NVC-1:0] push_vc;
    logic           pop_valid;
    logic [NVC-1:0] pop_vc;
    logic           push_ready;
    logic           write_valid;
    logic [4:0]     write_addr;
    logic           read_valid;
    logic [4:0]     read_addr;
    logic [NVC-1:0] vc_empty;
    logic [5:0]     free_count;
    logic           error;

    always #5 clk = ~clk;

    dvc_buffer_ctrl #(
        .max_vc_number(NVC),
        .memory_bank_depth(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .push_valid(push_valid),
        .push_vc(push_vc),
        .pop_valid(pop_valid),
        .pop_vc(pop_vc),
        .push_ready(push_ready),
        .write_valid(write_valid),
        .write_addr(write_addr),
        .read_valid(read_valid),
        .read_addr(read_addr),
        .vc_empty(vc_empty),
        .free_count(free_count),
        .error(error)
    );

    int n_vec  = 0;
    int n_fail = 0;

    int free_q [$];
    int vcq    [NVC][$];
    int sb_wr  [$];
    int sb_rd  [$];

    logic       cap_wv, cap_rv, cap_err;
    logic [4:0] cap_wa, cap_ra;
    logic [5:0] cap_free;

    typedef struct {
        logic           pv;
        logic [NVC-1:0] pvc;
        logic           ov;
        logic [NVC-1:0] ovc;
        logic           ewv;
        int             ewa;
        logic           erv;
        int             era;
        logic           eerr;
        int             efree;
    } vec_t;

    vec_t tbl [9];
    int   freed [$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NVC-1:0] v);
        for (int i = 0; i < NVC; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [NVC-1:0] oh(input int i);
        logic [NVC-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        free_q.delete();
        for (int i = 0; i < DEPTH; i++) free_q.push_back(i);
        for (int v = 0; v < NVC; v++) vcq[v].delete();
        sb_wr.delete();
        sb_rd.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_free"},  free_count, DEPTH);
        check({tag, "_empty"}, vc_empty, 10'h3ff);
        check({tag, "_ready"}, push_ready, 1);
        check({tag, "_err"},   error, 0);
        check({tag, "_wv"},    write_valid, 0);
        check({tag, "_rv"},    read_valid, 0);
    endtask

    task automatic do_reset();
        push_valid = 1'b0;
        push_vc    = '0;
        pop_valid  = 1'b0;
        pop_vc     = '0;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rst");
    endtask

    task automatic apply(input logic pv, input logic [NVC-1:0] pvc,
                         input logic ov, input logic [NVC-1:0] ovc);
        bit             push_ok, pop_ok, exp_err;
        int             pi, oi, slot, w, sum;
        logic [NVC-1:0] exp_empty;
        @(negedge clk);
        push_valid = pv;
        push_vc    = pvc;
        pop_valid  = ov;
        pop_vc     = ovc;
        #1;
        pi = oh_idx(pvc);
        oi = oh_idx(ovc);
        slot = 0;
        push_ok = pv && $onehot(pvc) && free_q.size() > 0;
        pop_ok  = ov && $onehot(ovc) && vcq[oi].size() > 0;
        exp_err = (pv && (!$onehot(pvc) || free_q.size() == 0)) ||
                  (ov && (!$onehot(ovc) || vcq[oi].size() == 0));
        if (push_ok) sb_wr.push_back(free_q[0]);
        if (pop_ok)  sb_rd.push_back(vcq[oi][0]);
        check("push_ready", push_ready, free_q.size() != 0);
        check("write_valid", write_valid, push_ok);
        check("read_valid", read_valid, pop_ok);
        if (write_valid) begin
            if (sb_wr.size() == 0) check("write_unexpected", 1, 0);
            else check("write_addr", write_addr, sb_wr.pop_front());
        end
        if (read_valid) begin
            if (sb_rd.size() == 0) check("read_unexpected", 1, 0);
            else check("read_addr", read_addr, sb_rd.pop_front());
        end
        sb_wr.delete();
        sb_rd.delete();
        cap_wv = write_valid;
        cap_wa = write_addr;
        cap_rv = read_valid;
        cap_ra = read_addr;
        if (pop_ok) slot = vcq[oi].pop_front();
        if (push_ok) begin
            w = free_q.pop_front();
            vcq[pi].push_back(w);
        end
        if (pop_ok) free_q.push_back(slot);
        @(posedge clk);
        #1;
        check("error", error, exp_err);
        check("free_count", free_count, free_q.size());
        for (int v = 0; v < NVC; v++) exp_empty[v] = (vcq[v].size() == 0);
        check("vc_empty", vc_empty, exp_empty);
        sum = free_count;
        for (int v = 0; v < NVC; v++) sum += dut.vc_count[v];
        check("invariant", sum, DEPTH);
        cap_err  = error;
        cap_free = free_count;
    endtask

    task automatic idle();
        apply(1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        int total, v;
        reset      = 1'b1;
        push_valid = 1'b0;
        push_vc    = '0;
        pop_valid  = 1'b0;
        pop_vc     = '0;

        // pv pvc ov ovc | wv wa rv ra err free
        tbl[0] = '{1'b1, 10'h001, 1'b0, 10'h000, 1'b1, 0, 1'b0, 0, 1'b0, 31};
        tbl[1] = '{1'b1, 10'h001, 1'b0, 10'h000, 1'b1, 1, 1'b0, 0, 1'b0, 30};
        tbl[2] = '{1'b1, 10'h001, 1'b0, 10'h000, 1'b1, 2, 1'b0, 0, 1'b0, 29};
        tbl[3] = '{1'b0, 10'h000, 1'b1, 10'h001, 1'b0, 0, 1'b1, 0, 1'b0, 30};
        tbl[4] = '{1'b0, 10'h000, 1'b1, 10'h001, 1'b0, 0, 1'b1, 1, 1'b0, 31};
        tbl[5] = '{1'b0, 10'h000, 1'b1, 10'h001, 1'b0, 0, 1'b1, 2, 1'b0, 32};
        tbl[6] = '{1'b0, 10'h000, 1'b1, 10'h020, 1'b0, 0, 1'b0, 0, 1'b1, 32};
        tbl[7] = '{1'b1, 10'h003, 1'b0, 10'h000, 1'b0, 0, 1'b0, 0, 1'b1, 32};
        tbl[8] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 0, 1'b0, 0, 1'b0, 32};

        do_reset();
        for (int k = 0; k < 9; k++) begin
            apply(tbl[k].pv, tbl[k].pvc, tbl[k].ov, tbl[k].ovc);
            check("tbl_wv", cap_wv, tbl[k].ewv);
            if (tbl[k].ewv) check("tbl_wa", cap_wa, tbl[k].ewa);
            check("tbl_rv", cap_rv, tbl[k].erv);
            if (tbl[k].erv) check("tbl_ra", cap_ra, tbl[k].era);
            check("tbl_err", cap_err, tbl[k].eerr);
            check("tbl_free", cap_free, tbl[k].efree);
        end
        check("tbl_vc0_empty", vc_empty[0], 1);

        // Interleaved VC1/VC2, drain VC2, then exhaust the bank on VC3.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, 10'h002, 1'b0, '0);
            apply(1'b1, 10'h004, 1'b0, '0);
        end
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, '0, 1'b1, 10'h004);
            check("seq37_ra", cap_ra, 2 * k + 1);
        end
        for (int k = 0; k < 28; k++) apply(1'b1, 10'h008, 1'b0, '0);
        check("seq37_free0", free_count, 0);
        check("seq37_ready0", push_ready, 0);
        apply(1'b1, 10'h008, 1'b0, '0);
        check("seq37_ovf_wv", cap_wv, 0);
        check("seq37_ovf_err", cap_err, 1);
        idle();
        check("seq37_err_clr", cap_err, 0);

        // Same-cycle push and pop on a single-flit VC.
        do_reset();
        apply(1'b1, 10'h010, 1'b0, '0);
        apply(1'b1, 10'h010, 1'b1, 10'h010);
        check("seq38_ra", cap_ra, 0);
        check("seq38_wa", cap_wa, 1);
        check("seq38_cnt", dut.vc_count[4], 1);
        apply(1'b0, '0, 1'b1, 10'h010);
        check("seq38_ra2", cap_ra, 1);
        check("seq38_empty", vc_empty[4], 1);

        // Fill, drain in random VC order, refill: slots come back in freed order.
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            apply(1'b1, oh($urandom_range(0, NVC - 1)), 1'b0, '0);
        end
        freed.delete();
        total = DEPTH;
        while (total > 0) begin
            do v = $urandom_range(0, NVC - 1); while (vcq[v].size() == 0);
            apply(1'b0, '0, 1'b1, oh(v));
            freed.push_back(cap_ra);
            total--;
        end
        for (int k = 0; k < DEPTH; k++) begin
            apply(1'b1, oh($urandom_range(0, NVC - 1)), 1'b0, '0);
            check("seq40_reissue", cap_wa, freed[k]);
        end

        // Random mixed traffic, including malformed one-hot codes.
        for (int k = 0; k < 200; k++) begin
            logic [NVC-1:0] pvc, ovc;
            pvc = ($urandom_range(0, 7) == 0) ? NVC'($urandom) : oh($urandom_range(0, NVC - 1));
            ovc = ($urandom_range(0, 7) == 0) ? NVC'($urandom) : oh($urandom_range(0, NVC - 1));
            apply(1'($urandom_range(0, 1)), pvc, 1'($urandom_range(0, 1)), ovc);
        end

        // Reset hitting mid-traffic takes effect without a clock edge.
        @(negedge clk);
        push_valid = 1'b1;
        push_vc    = 10'h001;
        pop_valid  = 1'b1;
        pop_vc     = 10'h002;
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        @(negedge clk);
        reset      = 1'b0;
        push_valid = 1'b0;
        pop_valid  = 1'b0;
        model_reset();
        apply(1'b1, 10'h200, 1'b0, '0);
        check("post_rst_wa", cap_wa, 0);
        apply(1'b0, '0, 1'b1, 10'h200);
        check("post_rst_ra", cap_ra, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
